// File: rtl/fp32_iter_divider.sv
// fp32_iter_divider: sequential single-precision divider, result = a_i / b_i.
// The mantissa quotient is produced by a restoring radix-2 loop, one bit per
// clock, under a start/busy/done handshake. Denormal inputs are flushed to zero.
// The default build truncates toward zero.
// Optional build macro FP_DIV_ROUND_EN: iterate one extra step for a guard bit
// and round to nearest, ties to even. This adds one cycle of latency.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             request, sampled only in IDLE
//   a_i, b_i          dividend / divisor packed {sign, exp, mant}
//   busy              high from the accepting edge until done
//   done              one-cycle pulse; result and flags valid from this cycle
//   result            packed quotient, held until overwritten by the next op
//   overflow          exponent overflow, result is signed infinity
//   underflow         exponent underflow, result is signed zero
//   div_by_zero       divisor is zero
module fp32_iter_divider #(
  parameter int unsigned EXP_W    = 8,
  parameter int unsigned MANT_W   = 23,
  parameter int unsigned EXP_BIAS = 127
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [EXP_W+MANT_W:0]   a_i,
  input  logic [EXP_W+MANT_W:0]   b_i,
  output logic                    busy,
  output logic                    done,
  output logic [EXP_W+MANT_W:0]   result,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    div_by_zero
);

  localparam int unsigned W  = 1 + EXP_W + MANT_W;
  localparam int unsigned RW = MANT_W + 2;
`ifdef FP_DIV_ROUND_EN
  localparam int unsigned STEPS = MANT_W + 3;
`else
  localparam int unsigned STEPS = MANT_W + 2;
`endif
  localparam int unsigned QW = STEPS;
  localparam int unsigned CW = $clog2(STEPS);
  localparam int unsigned EW = EXP_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_NORM} state_e;

  state_e              state_q, state_d;
  logic [RW-1:0]       r_q, r_d;
  logic [MANT_W:0]     d_q, d_d;
  logic [QW-1:0]       q_q, q_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                sign_q, sign_d;
  logic [EXP_W-1:0]    ea_q, ea_d, eb_q, eb_d;
  logic                a_zero_q, a_zero_d, b_zero_q, b_zero_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [W-1:0]        result_q, result_d;
  logic                ovf_q, ovf_d, unf_q, unf_d, dbz_q, dbz_d;

  // Operand unpacking: exponent zero means the value is zero.
  logic [EXP_W-1:0]    ea_in, eb_in;
  logic                a_zero_in, b_zero_in;
  assign ea_in     = a_i[EXP_W+MANT_W-1:MANT_W];
  assign eb_in     = b_i[EXP_W+MANT_W-1:MANT_W];
  assign a_zero_in = (ea_in == '0);
  assign b_zero_in = (eb_in == '0);

  // One restoring step.
  logic                r_ge;
  logic [RW-1:0]       r_rem, r_step;
  logic [QW-1:0]       q_step;
  assign r_ge   = (r_q >= {1'b0, d_q});
  assign r_rem  = r_ge ? (r_q - {1'b0, d_q}) : r_q;
  assign r_step = {r_rem[RW-2:0], 1'b0};
  assign q_step = {q_q[QW-2:0], r_ge};

  // Normalisation, exponent and result packing from the finished quotient.
  logic                int_bit, carry, ovf_c, unf_c;
  logic [MANT_W-1:0]   mant;
  logic [EW-1:0]       e_calc;
  logic [W-1:0]        res_pack;
  logic                pk_ovf, pk_unf, pk_dbz;
`ifdef FP_DIV_ROUND_EN
  logic [MANT_W-1:0]   mant_t;
  logic [MANT_W:0]     mant_r;
  logic                guard, sticky, round_up;
`endif

  always_comb begin
    int_bit = q_q[QW-1];
`ifdef FP_DIV_ROUND_EN
    mant_t   = int_bit ? q_q[MANT_W+1:2] : q_q[MANT_W:1];
    guard    = int_bit ? q_q[1] : q_q[0];
    // With the integer bit set there is one spare fraction bit; it joins sticky.
    sticky   = (int_bit & q_q[0]) | (r_q != '0);
    round_up = guard & (sticky | mant_t[0]);
    mant_r   = {1'b0, mant_t} + (MANT_W+1)'(round_up);
    mant     = mant_r[MANT_W-1:0];
    carry    = mant_r[MANT_W];
`else
    mant  = int_bit ? q_q[MANT_W:1] : q_q[MANT_W-1:0];
    carry = 1'b0;
`endif
    e_calc = EW'(ea_q) - EW'(eb_q) + EW'(EXP_BIAS) - EW'(!int_bit) + EW'(carry);
    ovf_c  = ($signed(e_calc) >= $signed(EW'((1 << EXP_W) - 1)));
    unf_c  = ($signed(e_calc) <= $signed(EW'(0)));
    pk_ovf = 1'b0;
    pk_unf = 1'b0;
    pk_dbz = 1'b0;
    if (a_zero_q && b_zero_q) begin
      pk_dbz   = 1'b1;
      res_pack = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
    end else if (b_zero_q) begin
      pk_dbz   = 1'b1;
      res_pack = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (a_zero_q) begin
      res_pack = {sign_q, {(EXP_W+MANT_W){1'b0}}};
    end else if (ovf_c) begin
      pk_ovf   = 1'b1;
      res_pack = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (unf_c) begin
      pk_unf   = 1'b1;
      res_pack = {sign_q, {(EXP_W+MANT_W){1'b0}}};
    end else begin
      res_pack = {sign_q, e_calc[EXP_W-1:0], mant};
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    d_d      = d_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    ea_d     = ea_q;
    eb_d     = eb_q;
    a_zero_d = a_zero_q;
    b_zero_d = b_zero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_d   = a_i[W-1] ^ b_i[W-1];
          ea_d     = ea_in;
          eb_d     = eb_in;
          a_zero_d = a_zero_in;
          b_zero_d = b_zero_in;
          r_d      = a_zero_in ? '0 : {2'b01, a_i[MANT_W-1:0]};
          d_d      = b_zero_in ? '0 : {1'b1, b_i[MANT_W-1:0]};
          q_d      = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          dbz_d    = 1'b0;
          state_d  = S_ITER;
        end
      end
      S_ITER: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(STEPS - 1)) state_d = S_NORM;
      end
      S_NORM: begin
        result_d = res_pack;
        ovf_d    = pk_ovf;
        unf_d    = pk_unf;
        dbz_d    = pk_dbz;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      r_q      <= '0;
      d_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      ea_q     <= '0;
      eb_q     <= '0;
      a_zero_q <= 1'b0;
      b_zero_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      d_q      <= d_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      ea_q     <= ea_d;
      eb_q     <= eb_d;
      a_zero_q <= a_zero_d;
      b_zero_q <= b_zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/fp32_iter_divider.md
Name: fp32_iter_divider

Overview:
- Sequential single-precision floating-point divider: result = a_i / b_i.
- Complements the combinational Booth multiplier in the multiplier datapath; shares its packing {S, E, M}, its truncating convention and its overflow flag style.
- Mantissa quotient comes from a restoring radix-2 loop, one quotient bit per clock, under a start/busy/done handshake.

Parameters:
- EXP_W, 8, exponent field width.
- MANT_W, 23, stored mantissa width (hidden bit implicit).
- EXP_BIAS, 127, exponent bias.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a_i  input  1+EXP_W+MANT_W  dividend {sign, exp, mant}.
- b_i  input  1+EXP_W+MANT_W  divisor {sign, exp, mant}.
- busy  output  1  high from the accepting edge until done is asserted.
- done  output  1  one-cycle pulse; result and flags are valid from this cycle.
- result  output  1+EXP_W+MANT_W  packed quotient; held until the next accepted start.
- overflow  output  1  exponent overflow; result forced to signed infinity.
- underflow  output  1  exponent underflow; result forced to signed zero.
- div_by_zero  output  1  divisor is zero.

Behaviour:
- Reset: on a rising edge with rst=1:
  - busy=0, done=0, result=0, all flags=0, state=IDLE.
  - Any in-flight operation is aborted and no done is produced for it.
  - rst has priority over start.
- States and transitions:
  - IDLE: on start=1 at edge k:
    - Latch the operands.
    - Unpack mantissas to 1.M (MANT_W+1 bits); exponent 0 means value zero, so denormals are flushed.
    - Set sign = a_sign XOR b_sign.
    - Set R = mA, D = mB, cnt = 0, busy = 1, done = 0, state = ITER.
  - ITER: one restoring step per edge:
    - If R >= D: q bit = 1 and R = R - D; otherwise q bit = 0.
    - Shift q left with the new bit; R = R << 1.
    - Width: R needs MANT_W+2 bits.
    - After MANT_W+2 steps (cnt = MANT_W+1), go to NORM.
  - NORM (one edge): pack the result, set done=1, busy=0, state=IDLE.
- Latency: start accepted at edge k; done=1 after edge k+MANT_W+3 (k+26 for defaults). Latency is fixed, including special cases.
- Next-start timing: done lasts exactly one cycle. A start sampled in the same cycle that done is high is accepted, giving back-to-back operation.
- start while busy: ignored; operands are not re-latched.
- Normalisation: q has MANT_W+2 bits, with q[MANT_W+1] as the integer bit. The mantissa quotient lies in (0.5, 2).
  - If q[MANT_W+1]=1: M = q[MANT_W:1], E = Ea - Eb + EXP_BIAS.
  - Else: M = q[MANT_W-1:0], E = Ea - Eb + EXP_BIAS - 1.
  - E is computed signed, EXP_W+2 bits wide.
  - Rounding: truncation (round toward zero).
- Exponent range:
  - E >= 2^EXP_W - 1: overflow=1, result = {sign, all-ones, 0}.
  - E <= 0: underflow=1, result = {sign, 0, 0}.
- Special cases, in priority order, evaluated in NORM:
  - b zero and a zero: div_by_zero=1, result = 0x7FC00000 (quiet NaN).
  - b zero only: div_by_zero=1, result = {sign, all-ones, 0}.
  - a zero only: result = {sign, 0, 0}; no flags.
- Inputs with exponent all-ones (Inf/NaN) are unsupported; result is undefined but the handshake still completes.
- Flags are cleared at the accepting edge and updated together with result in NORM.

Optional Feature:
- Macro: FP_DIV_ROUND_EN.
- Defined:
  - ITER runs MANT_W+3 steps, producing one guard bit.
  - Sticky = (final R != 0).
  - Round to nearest, ties to even.
  - A mantissa carry-out increments E before the overflow check.
  - Latency becomes k+MANT_W+4.
- Undefined: truncation as above; latency k+MANT_W+3.

Test Plan:
- 6.0 / 2.0: a=0x40C00000, b=0x40000000 -> result 0x40400000, done exactly 26 cycles after start, all flags 0.
- 1.0 / 3.0: a=0x3F800000, b=0x40400000 -> result 0x3EAAAAAA without FP_DIV_ROUND_EN; 0x3EAAAAAB with it, done 27 cycles after start.
- -1.5 / 0.5: a=0xBFC00000, b=0x3F000000 -> result 0xC0400000. Then start 0x3F800000 / 0x3F800000 in the done cycle -> 0x3F800000 after a further 26 cycles.
- Divide by zero:
  - a=0x3F800000, b=0x00000000 -> div_by_zero=1, result 0x7F800000.
  - a=b=0 -> div_by_zero=1, result 0x7FC00000.
  - a=0x00000000, b=0x40000000 -> result 0x00000000, flags 0.
- Exponent range:
  - a=0x7F000000, b=0x3E800000 -> overflow=1, result 0x7F800000.
  - a=0x00800000, b=0x40800000 -> underflow=1, result 0x00000000.
- Control:
  - Pulse start again at cycle 5 with different operands -> ignored, first result returned.
  - Assert rst at cycle 10 of an operation -> busy=0, result=0, and no done pulse in the following 40 cycles.
